// File: rtl/fp_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_adder_pipe
// Description : Pipelined (a + b) mod P over a prime field, valid/ready
//               stream with a side-band tag and sop/eop framing.
// Revision    : 1.0  initial release
// ============================================================================
module fp_adder_pipe #(
    parameter int                BITS     = 256,
    parameter logic [BITS-1:0]   P        = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
    parameter int                CTL_BITS = 8,
    parameter int                LEVEL    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_add_val,
    output logic                 i_add_rdy,
    input  logic [2*BITS-1:0]    i_add_dat,
    input  logic [CTL_BITS-1:0]  i_add_ctl,
    input  logic                 i_add_sop,
    input  logic                 i_add_eop,
    output logic                 o_add_val,
    input  logic                 o_add_rdy,
    output logic [BITS-1:0]      o_add_dat,
    output logic [CTL_BITS-1:0]  o_add_ctl,
    output logic                 o_add_sop,
    output logic                 o_add_eop
);

    localparam int C_CW = (BITS + LEVEL) / LEVEL;
    localparam int C_TW = C_CW * LEVEL;
    localparam logic [C_TW-1:0] C_P_EXT = C_TW'(P);

    logic w_en;
    assign w_en      = o_add_rdy | ~o_add_val;
    assign i_add_rdy = w_en;

    // Index k is the input of stage k; index LEVEL is the block output.
    logic [LEVEL:0]        w_val;
    logic [LEVEL:0]        w_sop;
    logic [LEVEL:0]        w_eop;
    logic [CTL_BITS-1:0]   w_ctl [LEVEL+1];
    logic [C_TW-1:0]       w_a   [LEVEL];
    logic [C_TW-1:0]       w_b   [LEVEL];
    logic [C_TW-1:0]       w_s   [LEVEL];
    logic [C_TW-1:0]       w_d   [LEVEL];
    logic [LEVEL-1:0]      w_c;
    logic [LEVEL-1:0]      w_bw;

    assign w_val[0] = i_add_val;
    assign w_sop[0] = i_add_sop;
    assign w_eop[0] = i_add_eop;
    assign w_ctl[0] = i_add_ctl;
    assign w_a[0]   = C_TW'(i_add_dat[BITS-1:0]);
    assign w_b[0]   = C_TW'(i_add_dat[2*BITS-1:BITS]);
    assign w_s[0]   = '0;
    assign w_d[0]   = '0;
    assign w_c[0]   = 1'b0;
    assign w_bw[0]  = 1'b0;

    generate
        for (genvar k = 0; k < LEVEL; k++) begin : g_stage
            logic [C_CW:0]         w_sum;
            logic [C_CW:0]         w_dif;
            logic [C_TW-1:0]       w_s_new;
            logic [C_TW-1:0]       w_d_new;
            logic                  val_q, val_d;
            logic                  sop_q, sop_d;
            logic                  eop_q, eop_d;
            logic [CTL_BITS-1:0]   ctl_q, ctl_d;

            // Sum chunk and the borrow chain of s - P over that same chunk.
            always_comb begin
                w_sum   = {1'b0, w_a[k][k*C_CW +: C_CW]}
                        + {1'b0, w_b[k][k*C_CW +: C_CW]}
                        + {{C_CW{1'b0}}, w_c[k]};
                w_dif   = {1'b0, w_sum[C_CW-1:0]}
                        - {1'b0, C_P_EXT[k*C_CW +: C_CW]}
                        - {{C_CW{1'b0}}, w_bw[k]};
                w_s_new = w_s[k];
                w_s_new[k*C_CW +: C_CW] = w_sum[C_CW-1:0];
                w_d_new = w_d[k];
                w_d_new[k*C_CW +: C_CW] = w_dif[C_CW-1:0];
            end

            always_comb begin
                val_d = val_q;
                sop_d = sop_q;
                eop_d = eop_q;
                ctl_d = ctl_q;
                if (w_en) begin
                    val_d = w_val[k];
                    sop_d = w_sop[k];
                    eop_d = w_eop[k];
                    ctl_d = w_ctl[k];
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    val_q <= 1'b0;
                    sop_q <= 1'b0;
                    eop_q <= 1'b0;
                    ctl_q <= '0;
                end else begin
                    val_q <= val_d;
                    sop_q <= sop_d;
                    eop_q <= eop_d;
                    ctl_q <= ctl_d;
                end
            end

            assign w_val[k+1] = val_q;
            assign w_sop[k+1] = sop_q;
            assign w_eop[k+1] = eop_q;
            assign w_ctl[k+1] = ctl_q;

            if (k < LEVEL-1) begin : g_mid
                logic [C_TW-1:0] a_q, a_d;
                logic [C_TW-1:0] b_q, b_d;
                logic [C_TW-1:0] s_q, s_d;
                logic [C_TW-1:0] d_q, d_d;
                logic            c_q, c_d;
                logic            bw_q, bw_d;

                always_comb begin
                    a_d  = a_q;
                    b_d  = b_q;
                    s_d  = s_q;
                    d_d  = d_q;
                    c_d  = c_q;
                    bw_d = bw_q;
                    if (w_en) begin
                        a_d  = w_a[k];
                        b_d  = w_b[k];
                        s_d  = w_s_new;
                        d_d  = w_d_new;
                        c_d  = w_sum[C_CW];
                        bw_d = w_dif[C_CW];
                    end
                end

                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        a_q  <= '0;
                        b_q  <= '0;
                        s_q  <= '0;
                        d_q  <= '0;
                        c_q  <= 1'b0;
                        bw_q <= 1'b0;
                    end else begin
                        a_q  <= a_d;
                        b_q  <= b_d;
                        s_q  <= s_d;
                        d_q  <= d_d;
                        c_q  <= c_d;
                        bw_q <= bw_d;
                    end
                end

                assign w_a[k+1]  = a_q;
                assign w_b[k+1]  = b_q;
                assign w_s[k+1]  = s_q;
                assign w_d[k+1]  = d_q;
                assign w_c[k+1]  = c_q;
                assign w_bw[k+1] = bw_q;
            end else begin : g_last
                logic [BITS-1:0] dat_q, dat_d;
                logic            w_unused;

                // A final borrow means s < P, so the unreduced sum is the answer.
                always_comb begin
                    dat_d = dat_q;
                    if (w_en) begin
                        dat_d = w_dif[C_CW] ? w_s_new[BITS-1:0] : w_d_new[BITS-1:0];
                    end
                end

                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        dat_q <= '0;
                    end else begin
                        dat_q <= dat_d;
                    end
                end

                assign o_add_dat = dat_q;
                assign w_unused  = ^{w_sum[C_CW], w_s_new[C_TW-1:BITS], w_d_new[C_TW-1:BITS]};
            end
        end
    endgenerate

    assign o_add_val = w_val[LEVEL];
    assign o_add_sop = w_sop[LEVEL];
    assign o_add_eop = w_eop[LEVEL];
    assign o_add_ctl = w_ctl[LEVEL];

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_adder_pipe
// Description : Bench for fp_adder_pipe at LEVEL 1, 2 and 4 in parallel,
//               scoreboarded against a plain modular-add model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp_adder_pipe;

    localparam logic [255:0] PRIME = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    typedef struct packed {
        logic [255:0] dat;
        logic [7:0]   ctl;
        logic         sop;
        logic         eop;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic check(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
        return s[255:0];
    endfunction

    function automatic logic [255:0] randop();
        logic [255:0] r;
        r = '0;
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = PRIME - 256'd1;
            default: begin
                for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
                r = r % PRIME;
            end
        endcase
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inst
            localparam int LV = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

            logic         rst, in_val, in_rdy, in_sop, in_eop;
            logic         out_val, out_rdy, out_sop, out_eop;
            logic [511:0] in_dat;
            logic [7:0]   in_ctl, out_ctl;
            logic [255:0] out_dat;

            item_t        exp_q[$];
            logic [263:0] bp_q[$];
            item_t        held, mon_e;
            bit           stall_prev = 1'b0;
            bit           bp_on = 1'b0;
            bit           rnd_done = 1'b0;

            fp_adder_pipe #(
                .BITS(256), .P(PRIME), .CTL_BITS(8), .LEVEL(LV)
            ) u_dut (
                .i_clk(clk), .i_rst(rst),
                .i_add_val(in_val), .i_add_rdy(in_rdy), .i_add_dat(in_dat),
                .i_add_ctl(in_ctl), .i_add_sop(in_sop), .i_add_eop(in_eop),
                .o_add_val(out_val), .o_add_rdy(out_rdy), .o_add_dat(out_dat),
                .o_add_ctl(out_ctl), .o_add_sop(out_sop), .o_add_eop(out_eop)
            );

            // Compare process: reflects the handshakes of the upcoming edge.
            always @(negedge clk) begin
                if (rst) begin
                    exp_q.delete();
                    stall_prev = 1'b0;
                end else begin
                    if (stall_prev)
                        check(out_val && ({out_dat, out_ctl, out_sop, out_eop} == held),
                              $sformatf("L%0d stable_while_stalled", LV), out_dat, held.dat);
                    if (out_val && !out_rdy) begin
                        check(!in_rdy, $sformatf("L%0d in_rdy_low_while_stalled", LV), in_rdy, 0);
                        held = {out_dat, out_ctl, out_sop, out_eop};
                        stall_prev = 1'b1;
                    end else begin
                        stall_prev = 1'b0;
                    end
                    if (out_val && out_rdy) begin
                        if (exp_q.size() == 0) begin
                            check(1'b0, $sformatf("L%0d unexpected_output ctl", LV), out_ctl, 0);
                        end else begin
                            mon_e = exp_q.pop_front();
                            check({out_dat, out_ctl, out_sop, out_eop} == mon_e,
                                  $sformatf("L%0d result ctl=%0h/%0h", LV, out_ctl, mon_e.ctl),
                                  out_dat, mon_e.dat);
                            if (bp_on) bp_q.push_back({out_dat, out_ctl});
                        end
                    end
                    if (in_val && in_rdy)
                        exp_q.push_back({fadd(in_dat[255:0], in_dat[511:256]), in_ctl, in_sop, in_eop});
                end
            end

            task automatic send(input logic [255:0] a, input logic [255:0] b, input logic [7:0] ctl,
                                input bit sop, input bit eop);
                bit took;
                int guard;
                in_val = 1'b1;
                in_dat = {b, a};
                in_ctl = ctl;
                in_sop = sop;
                in_eop = eop;
                took = 1'b0;
                guard = 0;
                while (!took) begin
                    @(negedge clk);
                    took = in_rdy;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (!took && guard > 500) begin
                        check(1'b0, $sformatf("L%0d send_timeout", LV), guard, 500);
                        took = 1'b1;
                    end
                end
            endtask

            task automatic directed(input logic [255:0] a, input logic [255:0] b, input logic [7:0] ctl,
                                    input logic [255:0] req, input string nm);
                send(a, b, ctl, 1'b1, 1'b1);
                in_val = 1'b0;
                for (int k = 1; k < LV; k++) begin
                    @(negedge clk);
                    check(!out_val, $sformatf("L%0d %s early_valid", LV, nm), out_val, 0);
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                check(out_val, $sformatf("L%0d %s valid_at_latency", LV, nm), out_val, 1);
                check(out_dat == req, $sformatf("L%0d %s dat", LV, nm), out_dat, req);
                check(out_ctl == ctl, $sformatf("L%0d %s ctl", LV, nm), out_ctl, ctl);
                @(posedge clk);
                #1;
            endtask

            task automatic drain(input string nm);
                int g;
                g = 0;
                while (exp_q.size() != 0 && g < 300) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                check(exp_q.size() == 0, $sformatf("L%0d %s drained", LV, nm), exp_q.size(), 0);
            endtask

            initial begin
                rst = 1'b1; in_val = 1'b0; in_dat = '0; in_ctl = '0;
                in_sop = 1'b0; in_eop = 1'b0; out_rdy = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check(!out_val, $sformatf("L%0d reset val", LV), out_val, 0);
                check(out_dat == '0, $sformatf("L%0d reset dat", LV), out_dat, 0);
                check(out_ctl == '0 && !out_sop && !out_eop, $sformatf("L%0d reset tag", LV), out_ctl, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                check(in_rdy, $sformatf("L%0d rdy_after_reset", LV), in_rdy, 1);
                @(posedge clk);
                #1 out_rdy = 1'b1;

                directed(256'd1, 256'd2, 8'h5A, 256'd3, "basic");
                directed(PRIME - 256'd1, 256'd1, 8'h11, 256'd0, "wrap_zero");
                directed(PRIME - 256'd1, PRIME - 256'd1, 8'h22, PRIME - 256'd2, "max_wrap");
                directed(256'd0, 256'd0, 8'h33, 256'd0, "zero");
                directed(PRIME - 256'd2, 256'd1, 8'h44, PRIME - 256'd1, "below_p");

                // Backpressure: 8 back-to-back pairs summing to P, stalled mid-stream.
                bp_on = 1'b1;
                fork
                    begin
                        for (int i = 0; i < 8; i++)
                            send(256'(i), PRIME - 256'(i), 8'(i), i == 0, i == 7);
                        in_val = 1'b0;
                    end
                    begin
                        repeat (3) @(posedge clk);
                        #1 out_rdy = 1'b0;
                        repeat (10) @(posedge clk);
                        #1 out_rdy = 1'b1;
                    end
                join
                drain("backpressure");
                bp_on = 1'b0;
                check(bp_q.size() == 8, $sformatf("L%0d bp count", LV), bp_q.size(), 8);
                for (int i = 0; i < 8 && i < bp_q.size(); i++)
                    check(bp_q[i] == {256'd0, 8'(i)}, $sformatf("L%0d bp item %0d", LV, i), bp_q[i][263:8], 0);

                // Reset with items in flight.
                for (int i = 0; i < 3; i++) send(randop(), randop(), 8'hA0 + 8'(i), 1'b0, 1'b0);
                in_val = 1'b0;
                rst = 1'b1;
                #1;
                check(!out_val, $sformatf("L%0d midreset val", LV), out_val, 0);
                check(out_dat == '0, $sformatf("L%0d midreset dat", LV), out_dat, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                for (int k = 0; k < LV + 3; k++) begin
                    @(negedge clk);
                    check(!out_val, $sformatf("L%0d no_stale_after_reset", LV), out_val, 0);
                    @(posedge clk);
                    #1;
                end
                directed(256'd7, 256'd8, 8'h78, 256'd15, "after_reset");

                // Random regression with gaps and random backpressure.
                fork
                    begin
                        for (int n = 0; n < 2000; n++) begin
                            while ($urandom_range(0, 3) == 0) begin
                                in_val = 1'b0;
                                @(posedge clk);
                                #1;
                            end
                            send(randop(), randop(), 8'($urandom), 1'($urandom), 1'($urandom));
                        end
                        in_val = 1'b0;
                        rnd_done = 1'b1;
                    end
                    begin
                        while (!rnd_done) begin
                            out_rdy = ($urandom_range(0, 3) != 0);
                            @(posedge clk);
                            #1;
                        end
                        out_rdy = 1'b1;
                    end
                join
                drain("random");
                n_done++;
            end
        end
    endgenerate

    initial begin
        int cyc;
        cyc = 0;
        while (n_done < 3 && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        if (n_done < 3) check(1'b0, "global_timeout", n_done, 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
